// File: rtl/onehot_dec_pkg.sv
// Shared encodings for the one-hot decoder / line scanner.
// Holds the FSM state type plus the mode and direction constants.
package onehot_dec_pkg;

  typedef enum logic {
    S_DEC  = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  localparam logic MODE_DEC  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Control and result bundle between a requester and onehot_decoder_seq.
// The master drives mode/select/direction; the slave (decoder) returns the pattern and pulses.
interface onehot_decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2**SEL_W;

  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             sel_vld;
  logic             dir;
  logic [OUT_W-1:0] out;
  logic             out_vld;
  logic             scan_wrap;

  modport master (
    output mode, sel, sel_vld, dir,
    input  out, out_vld, scan_wrap
  );

  modport slave (
    input  mode, sel, sel_vld, dir,
    output out, out_vld, scan_wrap
  );
endinterface

// File: rtl/scan_prescaler.sv
// Step-rate prescaler: counts while run=1 and flags the terminal count.
// Dropping run clears the count so every scan entry starts a full period.
module scan_prescaler #(
  parameter int             CNT_W   = 24,
  parameter logic [CNT_W-1:0] CNT_MAX = 24'd9_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic run,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear when idle or at terminal count, else increment
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a prescaled running-light scan mode.
// Define ONEHOT_DECODER_ACTIVE_LOW_EN for a one-cold output (common-anode LEDs).
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int               SEL_W   = 3,
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] CNT_MAX = 24'd9_999_999
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  onehot_decoder_seq_if.slave  bus
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] HOT0 = OUT_W'(1);
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_RST = ~HOT0;
`else
  localparam logic [OUT_W-1:0] OUT_RST = HOT0;
`endif

  function automatic logic [OUT_W-1:0] idx_pattern(input logic [SEL_W-1:0] idx);
`ifdef ONEHOT_DECODER_ACTIVE_LOW_EN
    idx_pattern = ~(HOT0 << idx);
`else
    idx_pattern = HOT0 << idx;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q;
  logic             out_vld_q, out_vld_d;
  logic             scan_wrap_q, scan_wrap_d;
  logic             run_s;
  logic             tick_s;

  // keep counting only while we stay in scan; any state change clears the count
  assign run_s = (state_q == S_SCAN) && (bus.mode == MODE_SCAN);

  scan_prescaler #(
    .CNT_W   (CNT_W),
    .CNT_MAX (CNT_MAX)
  ) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run       (run_s),
    .tick      (tick_s)
  );

  // next state, next index and event pulses
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_vld_d   = 1'b0;
    scan_wrap_d = 1'b0;
    case (state_q)
      S_DEC: begin
        if (bus.sel_vld) begin
          idx_d     = bus.sel;
          out_vld_d = 1'b1;
        end else begin
          idx_d = idx_q;
        end
        if (bus.mode == MODE_SCAN) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_DEC;
        end
      end
      S_SCAN: begin
        if (tick_s) begin
          if (bus.dir == DIR_UP) begin
            idx_d       = idx_q + SEL_W'(1);
            scan_wrap_d = (idx_q == {SEL_W{1'b1}});
          end else begin
            idx_d       = idx_q - SEL_W'(1);
            scan_wrap_d = (idx_q == {SEL_W{1'b0}});
          end
        end else begin
          idx_d = idx_q;
        end
        if (bus.mode == MODE_DEC) begin
          state_d = S_DEC;
        end else begin
          state_d = S_SCAN;
        end
      end
      default: begin
        state_d = S_DEC;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_DEC;
      idx_q       <= {SEL_W{1'b0}};
      out_q       <= OUT_RST;
      out_vld_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= idx_pattern(idx_d);
      out_vld_q   <= out_vld_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder for the LED/select-line fabric.
- Generalises the fixed 3-to-8 combinational decoder to SEL_W-to-2^SEL_W.
- Registered, latch-free output.
- Adds an autonomous scan mode (running light / line scanner) with a prescaled step rate, direction control and a wrap indication.

Parameters:
- SEL_W, 3, width of the binary select; OUT_W = 2**SEL_W is a derived localparam, not overridable.
- CNT_MAX, 24'd9_999_999, prescaler terminal count; one scan step every CNT_MAX+1 clocks.
- CNT_W, 24, prescaler counter width; must hold CNT_MAX.

Ports:
- sys_clk  input  1  system clock, all logic on the rising edge.
- sys_rst_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = decode mode, 1 = scan mode.
- sel  input  SEL_W  binary index to decode.
- sel_vld  input  1  qualifies sel; single-cycle strobe.
- dir  input  1  scan direction: 0 = up (bit k to k+1), 1 = down.
- out  output  OUT_W  one-hot output, registered.
- out_vld  output  1  one-cycle pulse when out changes due to a sel_vld decode.
- scan_wrap  output  1  one-cycle pulse when the scan index wraps.

Behaviour:
- Reset: one clock, one synchronous active-low reset (sys_clk, sys_rst_n); no other reset source. Sampled only on the sys_clk edge while sys_rst_n=0. State to S_DEC, idx=0, cnt=0, out=1 (bit 0 set), out_vld=0, scan_wrap=0. Reset mid-scan aborts immediately; no partial step is retained.
- Invariant: out has exactly one bit set in every cycle, including during reset and out of reset. There is no all-zero or multi-hot state.
- Internal state: idx (SEL_W bits) is the current position; out = 1<<idx (registered) at all times.
- FSM states and transitions:
  - S_DEC -> S_SCAN when mode=1.
  - S_SCAN -> S_DEC when mode=0.
  - mode is sampled every cycle; the transition takes effect on the next edge.
  - cnt clears to 0 on every state change.
- S_DEC:
  - sel_vld=1: idx <= sel and out <= 1<<sel on the next edge. out_vld=1 in that same cycle. Latency is 1 clock.
  - sel_vld=0: hold idx and out; out_vld=0.
  - Repeated sel_vld with the same sel still pulses out_vld.
  - cnt is held at 0; scan_wrap=0.
- S_SCAN:
  - sel/sel_vld are ignored; out_vld=0.
  - cnt increments each clock. At cnt==CNT_MAX: cnt <= 0 and idx steps by ±1 per dir, modulo OUT_W.
  - scan_wrap=1 for the cycle in which out takes the wrapped value: OUT_W-1 -> 0 going up, 0 -> OUT_W-1 going down.
  - dir is sampled only on the step cycle; changing dir between steps does not disturb cnt.
- Mode handover: scan starts from the idx last decoded. Returning to S_DEC keeps the current scan position until the next sel_vld.
- Simultaneous events:
  - mode 0->1 together with sel_vld=1: the decode is honoured, because the FSM is still in S_DEC that cycle.
  - The first scan step occurs CNT_MAX+1 clocks after entry.
- Arithmetic: idx wrap uses natural SEL_W-bit modular add/sub. cnt compares with == CNT_MAX, never >=.

Optional Feature:
- Macro: ONEHOT_DECODER_ACTIVE_LOW_EN.
- When defined: the out port drives ~(1<<idx) (one-cold, for common-anode LEDs). Reset value is all ones except bit 0 = 0. out_vld and scan_wrap are unaffected.
- When undefined: active-high one-hot as specified above.

Decomposition:
- Shared package onehot_dec_pkg holds:
  - the state encoding (S_DEC=1'b0, S_SCAN=1'b1);
  - the mode constants MODE_DEC/MODE_SCAN;
  - the direction constants DIR_UP/DIR_DN.
- One sub-module: scan_prescaler. It takes CNT_MAX/CNT_W, inputs sys_clk, sys_rst_n, run, and outputs a tick pulse at the terminal count. run=0 clears its counter.
- The top module holds the FSM, idx, and the output register.

Test Plan (SEL_W=3, CNT_MAX=3 in simulation):
- Reset: hold sys_rst_n=0 for 3 clocks -> out=8'b0000_0001, out_vld=0, scan_wrap=0. Release -> out stays 8'h01.
- Decode sweep: sel 0..7 each with a one-cycle sel_vld -> the next clock out = 8'h01, 02, 04 … 80, each with a single out_vld pulse. Without sel_vld, out holds.
- Scan up with wrap: sel=6 decoded, then mode=1, dir=0 -> out 8'h40 held 4 clocks, then 8'h80, then 8'h01 with scan_wrap=1 for exactly that cycle; period is 4 clocks.
- Scan down: from idx=1, dir=1 -> 8'h02 to 8'h01 to 8'h80 (scan_wrap=1) to 8'h40. sel_vld pulses during scan -> no out change, out_vld=0.
- Reset mid-scan: assert sys_rst_n=0 at cnt=2, idx=5 -> next edge out=8'h01, cnt=0, state S_DEC even with mode=1. After release, S_SCAN is re-entered with the first step 4 clocks later.
- With ONEHOT_DECODER_ACTIVE_LOW_EN: decode sel=3 -> out=8'b1111_0111. Reset -> out=8'hFE.
